traffic_light_ctrl_param: RTL and testbench

//  Demand-actuated, parametrised successor to the fixed-time four-signal junction controller.

---
 rtl/traffic_light_ctrl_param.sv | 150 +++++++++++++++
 tb/tb_traffic_light_ctrl_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_param.sv
// traffic_light_ctrl_param
//   Demand-actuated four-head junction controller (main-1, main-2, main-turn,
//   side). Phase lengths are counted in ticks from an internal prescaler.
//   Turn and side phases are skipped unless requested. A flash override
//   blinks the main heads yellow.
// Ports
//   clk        system clock, posedge
//   reset      synchronous, active-low
//   side_req   side-road demand (level or pulse)
//   turn_req   turn-lane demand (level or pulse)
//   flash_en   flash override (level)
//   light_M1/M2/MT/S  lamp codes: 001 green, 010 yellow, 100 red, 000 off
//   phase      current state code
//   side_pend  latched side demand
//   turn_pend  latched turn demand
module traffic_light_ctrl_param #(
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter int unsigned T_MG       = 7,
  parameter int unsigned T_TG       = 5,
  parameter int unsigned T_SG       = 3,
  parameter int unsigned T_Y        = 2,
  parameter int unsigned T_AR       = 1,
  parameter int unsigned FLASH_HALF = 1,
  parameter int unsigned CW         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       turn_req,
  input  logic       flash_en,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [3:0] phase,
  output logic       side_pend,
  output logic       turn_pend
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] OFF = 3'b000;

  typedef enum logic [3:0] {
    MAIN_GRN = 4'd0,
    MAIN_YEL = 4'd1,
    M2_YEL   = 4'd2,
    TURN_GRN = 4'd3,
    TURN_YEL = 4'd4,
    ALL_RED  = 4'd5,
    SIDE_GRN = 4'd6,
    SIDE_YEL = 4'd7,
    SIDE_CLR = 4'd8,
    FLASH    = 4'd9
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pre;
  logic          blink;
  logic          tick, expire;

  // Reload value (duration minus one) for the phase being entered.
  // In FLASH the counter times the blink half-period instead.
  function automatic logic [CW-1:0] dur_m1(input state_t s);
    case (s)
      MAIN_GRN:                           return CW'(T_MG - 1);
      MAIN_YEL, M2_YEL, TURN_YEL, SIDE_YEL: return CW'(T_Y - 1);
      TURN_GRN:                           return CW'(T_TG - 1);
      SIDE_GRN:                           return CW'(T_SG - 1);
      FLASH:                              return CW'(FLASH_HALF - 1);
      default:                            return CW'(T_AR - 1);
    endcase
  endfunction

  assign tick   = (pre == PW'(CLK_DIV - 1));
  assign expire = tick && (cnt == '0);

  always_comb begin
    nxt = state;
    case (state)
      MAIN_GRN: if (expire) nxt = turn_pend ? M2_YEL : (side_pend ? MAIN_YEL : MAIN_GRN);
      MAIN_YEL: if (expire) nxt = ALL_RED;
      M2_YEL:   if (expire) nxt = TURN_GRN;
      TURN_GRN: if (expire) nxt = TURN_YEL;
      TURN_YEL: if (expire) nxt = ALL_RED;
      ALL_RED:  if (expire) nxt = side_pend ? SIDE_GRN : MAIN_GRN;
      SIDE_GRN: if (expire) nxt = SIDE_YEL;
      SIDE_YEL: if (expire) nxt = SIDE_CLR;
      SIDE_CLR: if (expire) nxt = MAIN_GRN;
      FLASH:    nxt = SIDE_CLR;
      default:  nxt = SIDE_CLR;
    endcase
    // Flash overrides expiry, but an undefined code still recovers via SIDE_CLR.
    if (flash_en && (state <= FLASH)) nxt = FLASH;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SIDE_CLR;
      cnt       <= CW'(T_AR - 1);
      pre       <= '0;
      blink     <= 1'b1;
      side_pend <= 1'b0;
      turn_pend <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state) begin
        pre   <= '0;
        cnt   <= dur_m1(nxt);
        blink <= 1'b1;
      end else begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick) begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (state == FLASH) begin
            cnt   <= dur_m1(FLASH);
            blink <= ~blink;
          end
        end
      end
      // Clearing wins over a same-cycle request, so that request is absorbed.
      side_pend <= (nxt == SIDE_GRN && state != SIDE_GRN) ? 1'b0 : (side_pend | side_req);
      turn_pend <= (nxt == TURN_GRN && state != TURN_GRN) ? 1'b0 : (turn_pend | turn_req);
    end
  end

  always_comb begin
    {light_M1, light_M2, light_MT, light_S} = {R, R, R, R};
    case (state)
      MAIN_GRN: {light_M1, light_M2, light_MT, light_S} = {G, G, R, R};
      MAIN_YEL: {light_M1, light_M2, light_MT, light_S} = {Y, Y, R, R};
      M2_YEL:   {light_M1, light_M2, light_MT, light_S} = {G, Y, R, R};
      TURN_GRN: {light_M1, light_M2, light_MT, light_S} = {G, R, G, R};
      TURN_YEL: {light_M1, light_M2, light_MT, light_S} = {Y, R, Y, R};
      SIDE_GRN: {light_M1, light_M2, light_MT, light_S} = {R, R, R, G};
      SIDE_YEL: {light_M1, light_M2, light_MT, light_S} = {R, R, R, Y};
      FLASH:    {light_M1, light_M2, light_MT, light_S} =
                  blink ? {Y, Y, Y, R} : {OFF, OFF, OFF, OFF};
      default:  {light_M1, light_M2, light_MT, light_S} = {R, R, R, R};
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// tb_traffic_light_ctrl_param
//   Directed bench for traffic_light_ctrl_param with CLK_DIV=4 (one tick = 4 clk).
//   Phase lengths below are in clk: T_MG 28, T_TG 20, T_SG 12, T_Y 8, T_AR 4.
`timescale 1ns/1ps
module tb_traffic_light_ctrl_param;

  logic       clk = 1'b0;
  logic       reset, side_req, turn_req, flash_en;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic [3:0] phase;
  logic       side_pend, turn_pend;

  int passed = 0;
  int total  = 0;

  traffic_light_ctrl_param #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .side_req  (side_req),
    .turn_req  (turn_req),
    .flash_en  (flash_en),
    .light_M1  (light_M1),
    .light_M2  (light_M2),
    .light_MT  (light_MT),
    .light_S   (light_S),
    .phase     (phase),
    .side_pend (side_pend),
    .turn_pend (turn_pend)
  );

  always #5 clk = ~clk;

  function automatic int lamps();
    return int'({light_M1, light_M2, light_MT, light_S});
  endfunction

  // Expected lamps {M1,M2,MT,S} per phase (FLASH: on half).
  function automatic int exp_lamps(input int ph);
    case (ph)
      0:       return int'(12'b001_001_100_100);
      1:       return int'(12'b010_010_100_100);
      2:       return int'(12'b001_010_100_100);
      3:       return int'(12'b001_100_001_100);
      4:       return int'(12'b010_100_010_100);
      6:       return int'(12'b100_100_100_001);
      7:       return int'(12'b100_100_100_010);
      9:       return int'(12'b010_010_010_100);
      default: return int'(12'b100_100_100_100);
    endcase
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called on the first clk of a phase; checks code and lamps, then counts
  // how many clk the phase lasts and returns on the first clk of the next one.
  task automatic measure(input int ph, input int exp_len, input string tag);
    int n;
    n = 0;
    check({tag, "_phase"}, int'(phase), ph);
    check({tag, "_lamps"}, lamps(), exp_lamps(ph));
    while (int'(phase) == ph && n < 200) begin
      step();
      n++;
    end
    check({tag, "_len"}, n, exp_len);
  endtask

  task automatic wait_phase(input int ph, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(phase) != ph && n < budget) begin
      step();
      n++;
    end
    check({tag, "_reached"}, int'(phase), ph);
  endtask

  initial begin
    int n;
    int bad;

    // Reset, with flash_en asserted to show reset priority.
    reset = 1'b0; side_req = 1'b0; turn_req = 1'b0; flash_en = 1'b1;
    repeat (3) step();
    check("rst_phase", int'(phase), 8);
    check("rst_lamps", lamps(), exp_lamps(8));
    check("rst_pend", int'({side_pend, turn_pend}), 0);

    flash_en = 1'b0;
    reset    = 1'b1;
    measure(8, 4, "boot_clr");

    // Side request pulse 10 clk into main green: main green still lasts 28 clk.
    n = 0;
    while (int'(phase) == 0 && n < 200) begin
      side_req = (n == 10);
      step();
      n++;
    end
    side_req = 1'b0;
    check("mg_len", n, 28);
    check("side_pend_set", int'(side_pend), 1);
    measure(1, 8, "s_myel");
    measure(5, 4, "s_ar");
    check("side_pend_cleared", int'(side_pend), 0);
    measure(6, 12, "s_sg");
    measure(7, 8, "s_sy");
    measure(8, 4, "s_clr");
    check("s_back_main", int'(phase), 0);

    // No demand: main green holds.
    bad = 0;
    repeat (60) begin
      step();
      if (int'(phase) != 0 || lamps() != exp_lamps(0)) bad++;
    end
    check("main_hold", bad, 0);

    // Turn and side together.
    turn_req = 1'b1; side_req = 1'b1;
    step();
    turn_req = 1'b0; side_req = 1'b0;
    check("both_pend", int'({side_pend, turn_pend}), 3);
    wait_phase(2, 20, "ts_m2y");
    measure(2, 8, "ts_m2y");
    check("ts_turn_clear", int'({side_pend, turn_pend}), 2);
    measure(3, 20, "ts_tg");
    measure(4, 8, "ts_ty");
    measure(5, 4, "ts_ar");
    check("ts_side_clear", int'(side_pend), 0);
    measure(6, 12, "ts_sg");
    measure(7, 8, "ts_sy");
    measure(8, 4, "ts_clr");
    check("ts_back_main", int'(phase), 0);

    // Turn only: ALL_RED returns straight to main green.
    turn_req = 1'b1;
    step();
    turn_req = 1'b0;
    wait_phase(2, 40, "t_m2y");
    measure(2, 8, "t_m2y");
    measure(3, 20, "t_tg");
    measure(4, 8, "t_ty");
    measure(5, 4, "t_ar");
    check("t_skip_side", int'(phase), 0);

    // Flash in the middle of TURN_GRN.
    turn_req = 1'b1;
    step();
    turn_req = 1'b0;
    wait_phase(3, 60, "f_tg");
    repeat (5) step();
    flash_en = 1'b1;
    step();
    check("f_enter", int'(phase), 9);
    check("f_on0", lamps(), exp_lamps(9));
    side_req = 1'b1;
    repeat (3) step();
    side_req = 1'b0;
    check("f_on3", lamps(), exp_lamps(9));
    step();
    check("f_off0", lamps(), 0);
    repeat (3) step();
    check("f_off3", lamps(), 0);
    step();
    check("f_on_again", lamps(), exp_lamps(9));
    check("f_pend_kept", int'(side_pend), 1);
    flash_en = 1'b0;
    step();
    measure(8, 4, "f_exit_clr");
    check("f_back_main", int'(phase), 0);
    check("f_pend_after", int'(side_pend), 1);

    // Reset pulse mid SIDE_GRN (side demand left over from flash).
    wait_phase(6, 80, "r_sg");
    repeat (3) step();
    turn_req = 1'b1;
    step();
    turn_req = 1'b0;
    check("r_turn_pend", int'(turn_pend), 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("r_lamps", lamps(), exp_lamps(8));
    check("r_pend", int'({side_pend, turn_pend}), 0);
    measure(8, 4, "r_clr");
    check("r_resume", int'(phase), 0);
    check("r_resume_lamps", lamps(), exp_lamps(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
